// File: rtl/reg8_out.sv
// Eight-stage N-bit output staging register: delay line in load mode, block
// rotation in recirculate mode. Define REG8OUT_DRAIN_EN to drain instead of rotate.
module reg8_out #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,  // active-high asynchronous reset despite the name
  input  logic [N-1:0] in,
  input  logic         s,
  output logic [N-1:0] out
);

  logic [N-1:0] stage [8];
  logic [N-1:0] feed;

  // Word entering stage[0]: the input in load mode, otherwise the recirculated
  // (or zero, when draining) word.
  always_comb begin
    feed = in;
    if (s) begin
`ifdef REG8OUT_DRAIN_EN
      feed = '0;
`else
      feed = stage[7];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) stage[i] <= '0;
    end else begin
      stage[0] <= feed;
      for (int i = 1; i < 8; i++) stage[i] <= stage[i-1];
    end
  end

  assign out = stage[7];

endmodule

// File: tb/tb_reg8_out.sv
// Directed bench for reg8_out: reset, load latency, recirculate/drain,
// return to load mode, and asynchronous reset in mid-stream.
module tb_reg8_out;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic       s;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  reg8_out #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .s     (s),
    .out   (out)
  );

  // clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (out === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, out, exp);
    end
  endtask

  // drive inputs, take one rising edge, settle 2 time units past it
  task automatic step(input logic [7:0] din, input logic sv);
    in = din;
    s  = sv;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] exp_v;
    rst_n = 1'b0;
    in    = 8'hAA;
    s     = 1'b0;

    // asynchronous reset before any clock edge
    #1 rst_n = 1'b1;
    #1 check("reset_immediate", 8'h00);
    for (int e = 0; e < 3; e++) begin
      step(8'hAA, 1'b0);
      check("reset_held", 8'h00);
    end
    rst_n = 1'b0;

    // load 1,2,3,...: zero for 7 edges, then 1 after the 8th
    for (int e = 1; e <= 7; e++) begin
      step(8'(e), 1'b0);
      check("load_latency_zero", 8'h00);
    end
    step(8'd8, 1'b0);
    check("load_first_word", 8'd1);

    // recirculate 16 edges with in=FF: 2..8,1,2..8,1 (rotate) or 2..8 then 0 (drain)
    for (int e = 1; e <= 16; e++) begin
      step(8'hFF, 1'b1);
`ifdef REG8OUT_DRAIN_EN
      exp_v = (e <= 7) ? 8'(e + 1) : 8'h00;
      check("drain", exp_v);
`else
      exp_v = 8'((e % 8) + 1);
      check("recirculate", exp_v);
`endif
    end

    // return to load mode with in=20,21,...
    for (int e = 1; e <= 10; e++) begin
      step(8'(19 + e), 1'b0);
      if (e >= 8) exp_v = 8'(20 + e - 8);
`ifdef REG8OUT_DRAIN_EN
      else exp_v = 8'h00;
`else
      else exp_v = 8'(e + 1);
`endif
      check("mode_return", exp_v);
    end

    // reset mid-stream while in=17
    in = 8'd17;
    #3 rst_n = 1'b1;
    #1 check("midstream_reset_immediate", 8'h00);
    step(8'd17, 1'b0);
    check("midstream_reset_held", 8'h00);
    rst_n = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step(8'(40 + e), 1'b0);
      check("post_reset_zero", 8'h00);
    end
    step(8'd48, 1'b0);
    check("post_reset_first", 8'd41);
    step(8'd49, 1'b0);
    check("post_reset_second", 8'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg8_out.md
# reg8_out

Eight-stage, N-bit output staging register for the NPU datapath. In load mode it acts as an 8-deep delay line, capturing one word per clock and presenting the oldest word on `out`. In recirculate mode it freezes the input and rotates the eight held words, replaying the captured block on `out` with period 8.

## Interface
- `N`, default 8, word width of `in`, `out` and each stage.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  asynchronous, active-high reset; clears all stages while high, despite the name.
- `in`  input  N  data word, sampled on every rising edge while `s`=0.
- `out`  output  N  oldest stage, `stage[7]`; driven directly from a register, no combinational path from `in` or `s`.
- `s`  input  1  mode select: 0 = load/shift, 1 = recirculate.

## Operation
- Storage is `stage[0..7]`, each N bits. `stage[0]` is the newest word and `stage[7]` the oldest.
- `out` = `stage[7]` at all times.
- Reset (`rst_n`=1), asynchronous: all eight stages go to 0 immediately and `out`=0. Reset has priority over everything else.
- Load mode (`s`=0), on each rising edge:
  - `stage[0]` <= `in`
  - `stage[i]` <= `stage[i-1]` for i=1..7
  - the word in `stage[7]` is discarded.
- Recirculate mode (`s`=1), on each rising edge:
  - `stage[i]` <= `stage[i-1]` for i=1..7
  - `stage[0]` <= `stage[7]`
  - `in` is ignored.
- Switching `s` takes effect on the first edge where the new value is sampled. There is no pipeline flush and no per-stage valid tracking: stages not yet written read as 0 after reset.
- There is no stall or enable. The block shifts every cycle it is out of reset.
- The datapath has no arithmetic. Widths are uniform N bits with no truncation or extension.

## Timing
- Load-mode latency: a word sampled at rising edge k appears on `out` immediately after edge k+7, i.e. 7 edges later. It stays visible for one cycle while `s`=0.
- After reset release with `s`=0, `out` stays 0 for the first 7 edges. The first loaded word reaches `out` after the 8th edge.
- Recirculate mode: `out` repeats with period exactly 8 cycles. The sequence is the eight held words in age order, oldest first.
- Reset asserted mid-operation clears everything asynchronously, without waiting for a clock edge. The first edge after release behaves as a normal shift of zeros.
- `s` changing together with a rising edge: the block uses the value of `s` sampled at that edge.

## Configuration
- Macro: `REG8OUT_DRAIN_EN`.
- Defined: recirculate mode drains instead of rotating.
  - `stage[0]` <= 0 and the other stages shift as normal.
  - After 8 edges with `s`=1, all stages are 0.
  - The held block is therefore emitted exactly once, then `out`=0.
- Undefined (default): recirculate mode rotates as specified in Operation.
- Load mode and reset are identical in both builds.

## Test plan
- Reset: drive `in`=8'hAA, `s`=0 and assert `rst_n` with no clock edge. Required: `out`=0 immediately. Keep it 0 while reset stays high across multiple edges.
- Load latency: after reset release, `s`=0, drive `in`=1,2,3,… one value per edge. Required:
  - `out`=0 for the first 7 edges;
  - `out`=1 after the 8th edge, then 2, 3, … one per edge.
- Recirculate: load 1..8 with `s`=0, then set `s`=1 for 16 edges with `in`=8'hFF. Required:
  - `out` shows 1,2,…,8,1,2,…,8 in that order;
  - the value 8'hFF never appears on `out`.
- Drain (`REG8OUT_DRAIN_EN` defined): same stimulus as the recirculate case. Required: `out` shows 1..8 once, then 0 for every remaining edge.
- Mode return: after recirculating, set `s`=0 and drive `in`=20,21,…. Required: the remaining held words exit first, then 20 appears on `out` 7 edges after it was sampled.
- Reset mid-stream: assert `rst_n` while `in`=17 during a load sequence. Required: `out`=0 at once. After release, the first 7 edges of output are 0 before any new data appears.
